// File: rtl/boot_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
// Optional inter-byte timeout is enabled with BOOT_TIMEOUT_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_CSUM,
        S_DONE,
        S_ERR
    } boot_state_e;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready channel from the serial receiver into the loader.
interface imem_boot_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/boot_word_assembler.sv
// Big-endian byte-to-word assembler with running XOR checksum.
module boot_word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_ready,
    output logic [7:0]  csum
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
            csum_d  = '0;
        end else if (en) begin
            shift_d = {shift_q[15:0], din};
            cnt_d   = cnt_q + 2'd1;
            csum_d  = csum_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    // The final byte bypasses the register so the word is complete on its strobe.
    assign word       = {shift_q, din};
    assign word_ready = en && (cnt_q == 2'(WORD_BYTES - 1));
    assign csum       = csum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Frame parser: length, payload words into imem, checksum; gates CPU reset.
// Define BOOT_TIMEOUT_EN to resynchronise after TIMEOUT_CYC idle cycles.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    imem_boot_loader_if.slave rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

    boot_state_e state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic        accept;
    logic        asm_en;
    logic        asm_clr;
    logic [31:0] asm_word;
    logic        word_ready;
    logic [7:0]  csum;
    logic        to_fire;
    logic [16:0] len_n;
    logic        last_word;

    assign accept    = rx.rx_valid && rx_ready_q;
    assign asm_en    = accept && (state_q == S_WORD);
    assign len_n     = {1'b0, len_q[15:8], rx.rx_data};
    assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};

    boot_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (reset),
        .en         (asm_en),
        .clr        (asm_clr),
        .din        (rx.rx_data),
        .word       (asm_word),
        .word_ready (word_ready),
        .csum       (csum)
    );

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        to_run;

    assign to_run  = state_q inside {S_LEN_LO, S_WORD, S_CSUM};
    assign to_fire = to_run && !accept &&
                     (to_cnt_q == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d = '0;
        if (to_run && !accept && !to_fire) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_fire = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        asm_clr      = 1'b0;

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx.rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx.rx_data;
                    if (len_n > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_n == 17'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_WORD;
                    end
                end
            end
            S_WORD: begin
                if (word_ready && last_word) begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx.rx_data == csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        if (word_ready) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = asm_word;
            word_cnt_d   = word_cnt_q + CNT_W'(1);
        end

        // Idle timeout drops a partial frame and waits for a fresh header.
        if (to_fire) begin
            state_d    = S_LEN_HI;
            len_d      = '0;
            word_cnt_d = '0;
            asm_clr    = 1'b1;
        end

        rx_ready_d  = state_d inside {S_LEN_HI, S_LEN_LO, S_WORD, S_CSUM};
        cpu_reset_d = (state_d != S_DONE);
        load_done_d = (state_d == S_DONE);
        load_err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LEN_HI;
            len_q        <= '0;
            word_cnt_q   <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign rx.rx_ready = rx_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_reset   = cpu_reset_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frames, checksum, limits, resets.
// Timeout scenario depends on BOOT_TIMEOUT_EN.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    imem_boot_loader_if rx_if ();

    imem_boot_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .rx         (rx_if),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    int                wc[$];

    logic [7:0] frame_ok[11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                                 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h2D};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        forever begin
            if (rx_if.rx_ready === 1'b1) begin
                @(posedge clk);
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_byte_timeout got ready=%b exp 1",
                         rx_if.rx_ready);
                break;
            end
            @(negedge clk);
        end
        #1 rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_ok(input int gap_mode);
        int gaps[11] = '{1, 0, 2, 3, 0, 1, 0, 3, 2, 1, 2};
        for (int i = 0; i < 11; i++) begin
            send_byte(frame_ok[i]);
            if (gap_mode != 0) repeat (gaps[i]) @(posedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_two_writes(input string tag);
        checks++;
        if (wa.size() !== 2) begin
            errors++;
            $display("FAIL %s_wcount got %0d exp 2", tag, wa.size());
        end
        if (wa.size() == 2) begin
            checks++;
            if (wa[0] !== 8'd0 || wd[0] !== 32'h20080005) begin
                errors++;
                $display("FAIL %s_w0 got %h:%h exp 00:20080005",
                         tag, wa[0], wd[0]);
            end
            checks++;
            if (wa[1] !== 8'd1 || wd[1] !== 32'h00000000) begin
                errors++;
                $display("FAIL %s_w1 got %h:%h exp 01:00000000",
                         tag, wa[1], wd[1]);
            end
        end
    endtask

    task automatic check_flags(input string tag, input logic done,
                               input logic err, input logic cr,
                               input logic rdy);
        checks++;
        if ({load_done, load_err, cpu_reset, rx_if.rx_ready} !==
            {done, err, cr, rdy}) begin
            errors++;
            $display("FAIL %s_flags got d%b e%b cr%b r%b exp d%b e%b cr%b r%b",
                     tag, load_done, load_err, cpu_reset, rx_if.rx_ready,
                     done, err, cr, rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_flags("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_imem got we%b a%h d%h exp 0 0 0",
                     imem_we, imem_addr, imem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_flags("reset_release", 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_load_ok();
        int n0;
        do_reset();
        send_ok(0);
        check_two_writes("ok");
        if (wc.size() == 2) begin
            checks++;
            if (wc[1] - wc[0] !== 4) begin
                errors++;
                $display("FAIL ok_spacing got %0d exp 4", wc[1] - wc[0]);
            end
        end
        check_flags("ok", 1'b1, 1'b0, 1'b0, 1'b0);
        n0 = wa.size();
        rx_if.rx_data  = 8'hAA;
        rx_if.rx_valid = 1'b1;
        repeat (6) @(negedge clk);
        rx_if.rx_valid = 1'b0;
        checks++;
        if (wa.size() !== n0) begin
            errors++;
            $display("FAIL ignored_writes got %0d exp %0d", wa.size(), n0);
        end
        check_flags("ignored", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_csum();
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(frame_ok[i]);
        send_byte(8'h2C);
        repeat (3) @(negedge clk);
        check_two_writes("badcs");
        check_flags("badcs", 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (4) @(negedge clk);
        check_flags("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (wa.size() !== 0) begin
            errors++;
            $display("FAIL ovf_writes got %0d exp 0", wa.size());
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check_flags("zero", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wa.size() !== 0) begin
            errors++;
            $display("FAIL zero_writes got %0d exp 0", wa.size());
        end
    endtask

    task automatic test_max_words();
        logic [7:0]  cs;
        logic [31:0] w;
        logic [7:0]  iv;
        cs = 8'h00;
        do_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            w = {iv, 8'hA5, ~iv, 8'h3C};
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8]);
                cs = cs ^ w[k*8 +: 8];
            end
        end
        send_byte(cs);
        repeat (3) @(negedge clk);
        check_flags("max", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wa.size() !== 256) begin
            errors++;
            $display("FAIL max_wcount got %0d exp 256", wa.size());
        end
        if (wa.size() == 256) begin
            checks++;
            if (wa[0] !== 8'h00 || wd[0] !== 32'h00A5FF3C) begin
                errors++;
                $display("FAIL max_first got %h:%h exp 00:00a5ff3c",
                         wa[0], wd[0]);
            end
            checks++;
            if (wa[255] !== 8'hFF || wd[255] !== 32'hFFA5003C) begin
                errors++;
                $display("FAIL max_last got %h:%h exp ff:ffa5003c",
                         wa[255], wd[255]);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send_ok(1);
        check_two_writes("gaps");
        check_flags("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(frame_ok[i]);
        #3 rst_n = 1'b0;
        #1;
        check_flags("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== '0) begin
            errors++;
            $display("FAIL midrst_imem got we%b a%h exp 0 00",
                     imem_we, imem_addr);
        end
        do_reset();
        send_ok(0);
        check_two_writes("reload");
        check_flags("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(frame_ok[i]);
        repeat (20) @(negedge clk);
`ifdef BOOT_TIMEOUT_EN
        check_flags("tmo", 1'b0, 1'b0, 1'b1, 1'b1);
        send_ok(0);
`else
        check_flags("stall", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 5; i < 11; i++) send_byte(frame_ok[i]);
        repeat (3) @(negedge clk);
`endif
        check_two_writes("stall");
        check_flags("stall_end", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_ok();
        test_bad_csum();
        test_overflow();
        test_zero_len();
        test_max_words();
        test_gaps();
        test_reset_mid();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
